uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter DATA_BITS, default 8, width of each received byte.
REQ-002 Parameter MAX_PAYLOAD, default 16, maximum payload bytes per frame.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, inter-byte timeout in clk cycles.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx_empty  input  1  UART receive FIFO empty flag.
REQ-007 r_data  input  DATA_BITS  head byte of the UART receive FIFO; valid whenever rx_empty=0 (first-word fall-through).
REQ-008 parity_error  input  1  parity flag qualifying the current r_data.
REQ-009 rd_uart  output  1  pops one byte from the UART receive FIFO.
REQ-010 frame_valid  output  1  a complete, checked frame is presented.
REQ-011 frame_ready  input  1  consumer accepts the frame.
REQ-012 frame_len  output  5  payload byte count, 1..MAX_PAYLOAD.
REQ-013 frame_payload  output  MAX_PAYLOAD*DATA_BITS  payload; byte k occupies bits [8k+7:8k]; unused bytes are 0.
REQ-014 err_checksum, err_parity, err_len, err_timeout  output  1 each  single-cycle error pulses.

Function
REQ-015 Frame format: SYNC (0xA5), LEN, LEN payload bytes, CHK; CHK equals the XOR of LEN and all payload bytes.
REQ-016 rd_uart shall be combinational: rd_uart = !rx_empty && (state != HOLD); at most one pop per cycle.
REQ-017 FSM states: IDLE, LEN, PAYLOAD, CHECK, HOLD.
REQ-018 IDLE: a popped byte equal to 0xA5 moves to LEN; any other byte is discarded and the state stays IDLE.
REQ-019 LEN: if the popped byte is 0 or greater than MAX_PAYLOAD, pulse err_len and go to IDLE; otherwise latch it, initialise the XOR with it, and go to PAYLOAD.
REQ-020 PAYLOAD: store each popped byte at index = byte count, XOR it into the running checksum, and go to CHECK after the LENth byte.
REQ-021 CHECK: if the popped byte equals the running XOR, go to HOLD; otherwise pulse err_checksum and go to IDLE.
REQ-022 frame_valid shall assert in the cycle after the CHK byte is popped and stay high, with frame_len and frame_payload stable, until the frame_ready handshake.
REQ-023 HOLD with frame_ready=1 shall return to IDLE on the next edge; the next pop occurs no earlier than the following cycle.
REQ-024 A byte popped with parity_error=1 in any state except HOLD shall pulse err_parity, discard the partial frame, and return to IDLE (in IDLE the byte is only discarded).
REQ-025 In LEN, PAYLOAD or CHECK, TIMEOUT_CYCLES consecutive cycles with rx_empty=1 shall pulse err_timeout and return to IDLE; every pop clears the counter.
REQ-026 The payload buffer and frame_payload shall be cleared to 0 on entry to LEN, so bytes from a previous frame never leak into unused positions.
REQ-027 No more than one error pulse shall fire per cycle; parity takes precedence over len, checksum and timeout.

Reset
REQ-028 While reset=1: state=IDLE, rd_uart=0, frame_valid=0, frame_len=0, frame_payload=0, all error outputs 0, timeout counter and checksum 0.
REQ-029 Reset asserted mid-frame or in HOLD shall discard the frame without any error pulse.

Structure
REQ-030 Package uart_pkg shall hold SYNC_BYTE (0xA5) and the parser state enum typedef.
REQ-031 No sub-module is required; the timeout counter and the checksum accumulator are inline.

Verification
REQ-032 Frame A5,03,11,22,33,CHK=03^11^22^33=03 with frame_ready=1 -> frame_valid for one cycle, frame_len=3, payload bytes 0..2 = 11,22,33, upper bytes 0.
REQ-033 Same frame with CHK=04 -> err_checksum pulses once, frame_valid never asserts, and a following valid frame is accepted.
REQ-034 Bytes 00,7F,A5,00 -> the first two bytes are discarded, then err_len pulses; A5,11 -> err_len.
REQ-035 A5,02,AA followed by an idle rx_empty=1 for 1024 cycles -> err_timeout pulses on cycle 1024 and the state is IDLE.
REQ-036 A valid frame held with frame_ready=0 for 50 cycles while 3 bytes wait in the FIFO -> rd_uart=0 throughout and the outputs stay stable; on the release cycle no pop occurs, and popping resumes the next cycle.
REQ-037 Parity_error=1 on the second payload byte -> err_parity pulses and the state is IDLE; reset asserted in mid-PAYLOAD -> all outputs 0 with no error pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART frame parser.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHECK,
        HOLD
    } parser_state_t;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Bundles the UART receive FIFO side and the frame consumer side of the parser.
interface uart_frame_parser_if #(
    parameter int DATA_BITS   = 8,
    parameter int MAX_PAYLOAD = 16
);

    logic                             rx_empty;
    logic [DATA_BITS-1:0]             r_data;
    logic                             parity_error;
    logic                             rd_uart;
    logic                             frame_valid;
    logic                             frame_ready;
    logic [4:0]                       frame_len;
    logic [MAX_PAYLOAD*DATA_BITS-1:0] frame_payload;
    logic                             err_checksum;
    logic                             err_parity;
    logic                             err_len;
    logic                             err_timeout;

    // Master is the environment (FIFO + consumer); slave is the parser.
    modport master (
        output rx_empty, r_data, parity_error, frame_ready,
        input  rd_uart, frame_valid, frame_len, frame_payload,
        input  err_checksum, err_parity, err_len, err_timeout
    );

    modport slave (
        input  rx_empty, r_data, parity_error, frame_ready,
        output rd_uart, frame_valid, frame_len, frame_payload,
        output err_checksum, err_parity, err_len, err_timeout
    );

endinterface

// File: rtl/uart_frame_parser.sv
// Pops bytes from a first-word fall-through UART FIFO, assembles SYNC/LEN/payload/CHK
// frames, and holds each checked frame until the consumer accepts it.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int MAX_PAYLOAD    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic               clk,
    input logic               reset,
    uart_frame_parser_if.slave bus
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_BITS-1:0] SYNC_WORD  = DATA_BITS'(SYNC_BYTE);
    localparam logic [DATA_BITS-1:0] MAX_LEN    = DATA_BITS'(MAX_PAYLOAD);

    parser_state_t                    r_state;
    parser_state_t                    w_stateNext;
    logic [4:0]                       r_len;
    logic [4:0]                       r_count;
    logic [DATA_BITS-1:0]             r_xor;
    logic [MAX_PAYLOAD*DATA_BITS-1:0] r_payload;
    logic [TIMER_W-1:0]               r_timer;
    logic                             r_errChecksum;
    logic                             r_errParity;
    logic                             r_errLen;
    logic                             r_errTimeout;

    logic w_pop;
    logic w_byteOk;
    logic w_timeoutHit;
    logic w_lastPayload;
    logic w_errChecksum;
    logic w_errParity;
    logic w_errLen;
    logic w_errTimeout;

    // The FIFO is never popped while a finished frame waits for the consumer.
    assign w_pop         = !reset && !bus.rx_empty && (r_state != HOLD);
    assign w_byteOk      = w_pop && !bus.parity_error;
    assign w_timeoutHit  = (r_timer == TIMER_LAST);
    assign w_lastPayload = (r_count == (r_len - 5'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // The if/else order gives parity priority over the other error sources.
    always_comb begin
        w_stateNext   = r_state;
        w_errChecksum = 1'b0;
        w_errParity   = 1'b0;
        w_errLen      = 1'b0;
        w_errTimeout  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_byteOk && (bus.r_data == SYNC_WORD)) begin
                    w_stateNext = LEN;
                end
            end
            LEN: begin
                if (w_pop) begin
                    if (bus.parity_error) begin
                        w_errParity = 1'b1;
                        w_stateNext = IDLE;
                    end else if ((bus.r_data == '0) || (bus.r_data > MAX_LEN)) begin
                        w_errLen    = 1'b1;
                        w_stateNext = IDLE;
                    end else begin
                        w_stateNext = PAYLOAD;
                    end
                end else if (w_timeoutHit) begin
                    w_errTimeout = 1'b1;
                    w_stateNext  = IDLE;
                end
            end
            PAYLOAD: begin
                if (w_pop) begin
                    if (bus.parity_error) begin
                        w_errParity = 1'b1;
                        w_stateNext = IDLE;
                    end else if (w_lastPayload) begin
                        w_stateNext = CHECK;
                    end
                end else if (w_timeoutHit) begin
                    w_errTimeout = 1'b1;
                    w_stateNext  = IDLE;
                end
            end
            CHECK: begin
                if (w_pop) begin
                    if (bus.parity_error) begin
                        w_errParity = 1'b1;
                        w_stateNext = IDLE;
                    end else if (bus.r_data == r_xor) begin
                        w_stateNext = HOLD;
                    end else begin
                        w_errChecksum = 1'b1;
                        w_stateNext   = IDLE;
                    end
                end else if (w_timeoutHit) begin
                    w_errTimeout = 1'b1;
                    w_stateNext  = IDLE;
                end
            end
            HOLD: begin
                if (bus.frame_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Payload is zeroed when SYNC is accepted so short frames never expose stale bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len         <= '0;
            r_count       <= '0;
            r_xor         <= '0;
            r_payload     <= '0;
            r_timer       <= '0;
            r_errChecksum <= 1'b0;
            r_errParity   <= 1'b0;
            r_errLen      <= 1'b0;
            r_errTimeout  <= 1'b0;
        end else begin
            r_errChecksum <= w_errChecksum;
            r_errParity   <= w_errParity;
            r_errLen      <= w_errLen;
            r_errTimeout  <= w_errTimeout;
            if (w_pop || w_timeoutHit || (r_state == IDLE) || (r_state == HOLD)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_stateNext == LEN) begin
                        r_payload <= '0;
                        r_len     <= '0;
                        r_count   <= '0;
                        r_xor     <= '0;
                    end
                end
                LEN: begin
                    if (w_stateNext == PAYLOAD) begin
                        r_len   <= 5'(bus.r_data);
                        r_xor   <= bus.r_data;
                        r_count <= '0;
                    end
                end
                PAYLOAD: begin
                    if (w_byteOk) begin
                        r_payload[r_count*DATA_BITS +: DATA_BITS] <= bus.r_data;
                        r_xor   <= r_xor ^ bus.r_data;
                        r_count <= r_count + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rd_uart       = w_pop;
    assign bus.frame_valid   = !reset && (r_state == HOLD);
    assign bus.frame_len     = r_len;
    assign bus.frame_payload = r_payload;
    assign bus.err_checksum  = r_errChecksum;
    assign bus.err_parity    = r_errParity;
    assign bus.err_len       = r_errLen;
    assign bus.err_timeout   = r_errTimeout;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: a queue models the first-word fall-through FIFO.
module tb_uart_frame_parser;
    import uart_pkg::*;

    logic clk;
    logic reset;

    uart_frame_parser_if #(.DATA_BITS(8), .MAX_PAYLOAD(16)) ifc ();

    uart_frame_parser #(
        .DATA_BITS      (8),
        .MAX_PAYLOAD    (16),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
    } fifo_entry_t;

    fifo_entry_t fifo[$];
    int compared;
    int mismatched;
    int popCount;
    int validCycles;
    int errChkCount;
    int errParCount;
    int errLenCount;
    int errTmoCount;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive();
        if (fifo.size() == 0) begin
            ifc.rx_empty     = 1'b1;
            ifc.r_data       = 8'h00;
            ifc.parity_error = 1'b0;
        end else begin
            ifc.rx_empty     = 1'b0;
            ifc.r_data       = fifo[0].data;
            ifc.parity_error = fifo[0].par;
        end
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        fifo_entry_t e;
        e.data = d;
        e.par  = p;
        fifo.push_back(e);
        drive();
    endtask

    // Bytes are right-aligned: the first of n bytes sits in the most significant used slot.
    task automatic pushPacked(input logic [159:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            push(bytes[8*(n-1-i) +: 8], 1'b0);
        end
    endtask

    task automatic tick();
        logic willPop;
        fifo_entry_t dropped;
        @(negedge clk);
        willPop = ifc.rd_uart;
        @(posedge clk);
        #1;
        if (willPop && (fifo.size() > 0)) begin
            dropped = fifo.pop_front();
            popCount++;
        end
        drive();
        #1;
        validCycles += int'(ifc.frame_valid);
        errChkCount += int'(ifc.err_checksum);
        errParCount += int'(ifc.err_parity);
        errLenCount += int'(ifc.err_len);
        errTmoCount += int'(ifc.err_timeout);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clearStats();
        popCount    = 0;
        validCycles = 0;
        errChkCount = 0;
        errParCount = 0;
        errLenCount = 0;
        errTmoCount = 0;
    endtask

    task automatic test_reset();
        clearStats();
        reset = 1'b1;
        push(8'h55, 1'b0);
        ticks(2);
        compared++;
        if (dut.r_state !== IDLE) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got %0d want %0d", dut.r_state, IDLE);
        end
        compared++;
        if ({ifc.rd_uart, ifc.frame_valid} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_rd_valid: got %b want 00", {ifc.rd_uart, ifc.frame_valid});
        end
        compared++;
        if ((ifc.frame_len !== 5'd0) || (ifc.frame_payload !== 128'h0)) begin
            mismatched++;
            $display("[TB] FAIL reset_frame: got len %0d payload %h want 0/0", ifc.frame_len, ifc.frame_payload);
        end
        compared++;
        if ({ifc.err_checksum, ifc.err_parity, ifc.err_len, ifc.err_timeout} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_errors: got %b want 0000",
                     {ifc.err_checksum, ifc.err_parity, ifc.err_len, ifc.err_timeout});
        end
        reset = 1'b0;
        #1;
        compared++;
        if (ifc.rd_uart !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL release_rd: got %b want 1", ifc.rd_uart);
        end
        tick();
        compared++;
        if ((popCount !== 1) || (dut.r_state !== IDLE)) begin
            mismatched++;
            $display("[TB] FAIL idle_discard: got pops %0d state %0d want 1/%0d", popCount, dut.r_state, IDLE);
        end
    endtask

    task automatic test_good_frame();
        clearStats();
        ifc.frame_ready = 1'b1;
        pushPacked({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}, 6);
        ticks(6);
        compared++;
        if ((ifc.frame_valid !== 1'b1) || (ifc.frame_len !== 5'd3)) begin
            mismatched++;
            $display("[TB] FAIL good_valid_len: got valid %b len %0d want 1/3", ifc.frame_valid, ifc.frame_len);
        end
        compared++;
        if (ifc.frame_payload !== 128'h332211) begin
            mismatched++;
            $display("[TB] FAIL good_payload: got %h want %h", ifc.frame_payload, 128'h332211);
        end
        tick();
        compared++;
        if ((validCycles !== 1) || (dut.r_state !== IDLE)) begin
            mismatched++;
            $display("[TB] FAIL good_one_cycle: got valid cycles %0d state %0d want 1/%0d", validCycles, dut.r_state, IDLE);
        end
        compared++;
        if ((errChkCount + errParCount + errLenCount + errTmoCount) !== 0) begin
            mismatched++;
            $display("[TB] FAIL good_no_error: got %0d error pulses want 0",
                     errChkCount + errParCount + errLenCount + errTmoCount);
        end
    endtask

    task automatic test_bad_checksum();
        clearStats();
        pushPacked({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04}, 6);
        ticks(6);
        compared++;
        if ((ifc.err_checksum !== 1'b1) || (ifc.frame_valid !== 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL chk_pulse: got err %b valid %b want 1/0", ifc.err_checksum, ifc.frame_valid);
        end
        pushPacked({8'hA5, 8'h01, 8'h5A, 8'h5B}, 4);
        ticks(4);
        compared++;
        if ((ifc.frame_valid !== 1'b1) || (ifc.frame_len !== 5'd1) || (ifc.frame_payload !== 128'h5A)) begin
            mismatched++;
            $display("[TB] FAIL chk_recover: got valid %b len %0d payload %h want 1/1/5a",
                     ifc.frame_valid, ifc.frame_len, ifc.frame_payload);
        end
        tick();
        compared++;
        if ((errChkCount !== 1) || (validCycles !== 1)) begin
            mismatched++;
            $display("[TB] FAIL chk_counts: got chk %0d valid %0d want 1/1", errChkCount, validCycles);
        end
    endtask

    task automatic test_bad_len();
        clearStats();
        pushPacked({8'h00, 8'h7F, 8'hA5, 8'h00}, 4);
        ticks(3);
        compared++;
        if ((errLenCount !== 0) || (popCount !== 3) || (dut.r_state !== LEN)) begin
            mismatched++;
            $display("[TB] FAIL len_prefix: got err %0d pops %0d state %0d want 0/3/%0d",
                     errLenCount, popCount, dut.r_state, LEN);
        end
        tick();
        compared++;
        if ((ifc.err_len !== 1'b1) || (dut.r_state !== IDLE)) begin
            mismatched++;
            $display("[TB] FAIL len_zero: got err %b state %0d want 1/%0d", ifc.err_len, dut.r_state, IDLE);
        end
        pushPacked({8'hA5, 8'h11}, 2);
        ticks(2);
        compared++;
        if ((ifc.err_len !== 1'b1) || (errLenCount !== 2) || (dut.r_state !== IDLE)) begin
            mismatched++;
            $display("[TB] FAIL len_17: got err %b count %0d state %0d want 1/2/%0d",
                     ifc.err_len, errLenCount, dut.r_state, IDLE);
        end
    endtask

    task automatic test_max_payload();
        clearStats();
        pushPacked({8'hA5, 8'h10}, 2);
        for (int i = 1; i <= 16; i++) begin
            push(8'(i), 1'b0);
        end
        push(8'h00, 1'b0);
        ticks(19);
        compared++;
        if ((ifc.frame_valid !== 1'b1) || (ifc.frame_len !== 5'd16)) begin
            mismatched++;
            $display("[TB] FAIL max_valid_len: got valid %b len %0d want 1/16", ifc.frame_valid, ifc.frame_len);
        end
        compared++;
        if (ifc.frame_payload !== 128'h100F0E0D0C0B0A090807060504030201) begin
            mismatched++;
            $display("[TB] FAIL max_payload: got %h want %h", ifc.frame_payload,
                     128'h100F0E0D0C0B0A090807060504030201);
        end
        tick();
        compared++;
        if ((errChkCount + errParCount + errLenCount + errTmoCount) !== 0) begin
            mismatched++;
            $display("[TB] FAIL max_no_error: got %0d error pulses want 0",
                     errChkCount + errParCount + errLenCount + errTmoCount);
        end
    endtask

    task automatic test_timeout();
        clearStats();
        pushPacked({8'hA5, 8'h02, 8'hAA}, 3);
        ticks(3);
        ticks(1023);
        compared++;
        if ((errTmoCount !== 0) || (dut.r_state !== PAYLOAD)) begin
            mismatched++;
            $display("[TB] FAIL timeout_early: got pulses %0d state %0d want 0/%0d", errTmoCount, dut.r_state, PAYLOAD);
        end
        tick();
        compared++;
        if ((ifc.err_timeout !== 1'b1) || (dut.r_state !== IDLE)) begin
            mismatched++;
            $display("[TB] FAIL timeout_fire: got err %b state %0d want 1/%0d", ifc.err_timeout, dut.r_state, IDLE);
        end
        tick();
        compared++;
        if ((ifc.err_timeout !== 1'b0) || (errTmoCount !== 1)) begin
            mismatched++;
            $display("[TB] FAIL timeout_single: got err %b count %0d want 0/1", ifc.err_timeout, errTmoCount);
        end
    endtask

    task automatic test_back_to_back_hold();
        int holdBad;
        clearStats();
        ifc.frame_ready = 1'b0;
        pushPacked({8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD, 8'h77, 8'h88, 8'h99}, 8);
        ticks(5);
        holdBad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ((ifc.frame_valid !== 1'b1) || (ifc.frame_len !== 5'd2) ||
                (ifc.frame_payload !== 128'h3CC3) || (ifc.rd_uart !== 1'b0)) begin
                holdBad++;
            end
        end
        compared++;
        if ((holdBad !== 0) || (popCount !== 5)) begin
            mismatched++;
            $display("[TB] FAIL hold_stable: got bad cycles %0d pops %0d want 0/5", holdBad, popCount);
        end
        ifc.frame_ready = 1'b1;
        #1;
        compared++;
        if (ifc.rd_uart !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL release_no_pop: got rd %b want 0", ifc.rd_uart);
        end
        tick();
        compared++;
        if ((popCount !== 5) || (ifc.frame_valid !== 1'b0) || (ifc.rd_uart !== 1'b1)) begin
            mismatched++;
            $display("[TB] FAIL release_edge: got pops %0d valid %b rd %b want 5/0/1",
                     popCount, ifc.frame_valid, ifc.rd_uart);
        end
        ticks(3);
        compared++;
        if ((popCount !== 8) || (validCycles !== 51) || (dut.r_state !== IDLE)) begin
            mismatched++;
            $display("[TB] FAIL resume_pop: got pops %0d valid %0d state %0d want 8/51/%0d",
                     popCount, validCycles, dut.r_state, IDLE);
        end
    endtask

    task automatic test_parity();
        clearStats();
        pushPacked({8'hA5, 8'h03, 8'h11}, 3);
        push(8'h22, 1'b1);
        pushPacked({8'h33, 8'h03}, 2);
        ticks(4);
        compared++;
        if ((ifc.err_parity !== 1'b1) || (dut.r_state !== IDLE)) begin
            mismatched++;
            $display("[TB] FAIL parity_payload: got err %b state %0d want 1/%0d", ifc.err_parity, dut.r_state, IDLE);
        end
        ticks(2);
        push(8'hA5, 1'b0);
        push(8'h00, 1'b1);
        ticks(2);
        compared++;
        if ((ifc.err_parity !== 1'b1) || (ifc.err_len !== 1'b0) || (errLenCount !== 0)) begin
            mismatched++;
            $display("[TB] FAIL parity_precedence: got parity %b len %b len count %0d want 1/0/0",
                     ifc.err_parity, ifc.err_len, errLenCount);
        end
        push(8'hA5, 1'b1);
        tick();
        compared++;
        if ((dut.r_state !== IDLE) || (validCycles !== 0) || (errParCount !== 2)) begin
            mismatched++;
            $display("[TB] FAIL parity_sync: got state %0d valid %0d parity %0d want %0d/0/2",
                     dut.r_state, validCycles, errParCount, IDLE);
        end
    endtask

    task automatic test_reset_mid_frame();
        clearStats();
        pushPacked({8'hA5, 8'h04, 8'h01, 8'h02}, 4);
        ticks(3);
        reset = 1'b1;
        #1;
        compared++;
        if (ifc.rd_uart !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_rd: got %b want 0", ifc.rd_uart);
        end
        tick();
        compared++;
        if ((dut.r_state !== IDLE) || (ifc.frame_valid !== 1'b0) || (ifc.frame_len !== 5'd0) ||
            (ifc.frame_payload !== 128'h0) || (popCount !== 3)) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_clear: got state %0d valid %b len %0d payload %h pops %0d want %0d/0/0/0/3",
                     dut.r_state, ifc.frame_valid, ifc.frame_len, ifc.frame_payload, popCount, IDLE);
        end
        compared++;
        if ((errChkCount + errParCount + errLenCount + errTmoCount) !== 0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_no_error: got %0d error pulses want 0",
                     errChkCount + errParCount + errLenCount + errTmoCount);
        end
        fifo.delete();
        drive();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        reset           = 1'b1;
        ifc.frame_ready = 1'b0;
        clearStats();
        drive();
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_len();
        test_max_payload();
        test_timeout();
        test_back_to_back_hold();
        test_parity();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
